// File: rtl/escalonador_sensores_pkg.sv
// -----------------------------------------------------------------------------
// escalonador_sensores_pkg
// Shared definitions for the ultrasonic sensor scheduler:
//   - estado_t      : 3-bit state encoding of the scheduler FSM
//   - MEDIDA_TIMEOUT: BCD value latched when a measurement times out
//   - *_PADRAO      : default cycle constants (50 MHz system clock)
// Optional feature macro: ESCALONADOR_CONTINUO_EN (used by the FSM file).
// -----------------------------------------------------------------------------
package escalonador_sensores_pkg;

  typedef enum logic [2:0] {
    inicial     = 3'd0,
    prepara     = 3'd1,
    dispara     = 3'd2,
    espera_echo = 3'd3,
    mede        = 3'd4,
    registra    = 3'd5,
    intervalo   = 3'd6,
    fim         = 3'd7
  } estado_t;

  // "999" in BCD marks a measurement with no usable echo.
  localparam logic [11:0] MEDIDA_TIMEOUT = 12'h999;

  localparam int N_SENSORES_PADRAO       = 4;
  localparam int LARGURA_TRIGGER_PADRAO  = 500;        // 10 us at 50 MHz
  localparam int TIMEOUT_CICLOS_PADRAO   = 1_500_000;
  localparam int INTERVALO_CICLOS_PADRAO = 3_000_000;

endpackage

// File: rtl/escalonador_sensores_if.sv
// -----------------------------------------------------------------------------
// escalonador_sensores_if
// Bundle of the scheduler's sensor-side, counter-side and result signals.
//   medir, echo, pronto_cm, medida_cm : into the scheduler
//   trigger, pulso_cm, reset_cm       : to sensor pins / contador_cm
//   medida, sensor, timeout, valido   : latched result and its strobe
//   ocupado, fim_rodada, estado       : status and FSM debug view
// Result semantics: there is no back-pressure. valido is a one-cycle strobe;
// medida/sensor/timeout already hold the new result in the cycle valido is
// high and keep it until the next strobe or reset. The consumer must take the
// result in that cycle or read the held registers later.
// modport slave  : the scheduler
// modport master : whatever drives the sensors/counter side (bench, top level)
// -----------------------------------------------------------------------------
interface escalonador_sensores_if #(
  parameter int N_SENSORES = 4
);
  import escalonador_sensores_pkg::*;

  localparam int LARGURA_SENSOR = (N_SENSORES > 1) ? $clog2(N_SENSORES) : 1;

  logic                      medir;
  logic [N_SENSORES-1:0]     echo;
  logic                      pronto_cm;
  logic [11:0]               medida_cm;
  logic [N_SENSORES-1:0]     trigger;
  logic                      pulso_cm;
  logic                      reset_cm;
  logic [11:0]               medida;
  logic [LARGURA_SENSOR-1:0] sensor;
  logic                      valido;
  logic                      timeout;
  logic                      ocupado;
  logic                      fim_rodada;
  estado_t                   estado;

  modport slave (
    input  medir, echo, pronto_cm, medida_cm,
    output trigger, pulso_cm, reset_cm, medida, sensor, valido, timeout,
           ocupado, fim_rodada, estado
  );

  modport master (
    output medir, echo, pronto_cm, medida_cm,
    input  trigger, pulso_cm, reset_cm, medida, sensor, valido, timeout,
           ocupado, fim_rodada, estado
  );

endinterface

// File: rtl/escalonador_sensores_uc.sv
// -----------------------------------------------------------------------------
// escalonador_sensores_uc
// Control FSM of the sensor scheduler (Moore outputs are decoded from
// `estado` in the top level).
// Inputs : clock, reset (async, active-high), medir, echo_sel (echo of the
//          selected sensor), pronto_cm, fim_trigger / fim_timeout /
//          fim_intervalo (shared counter reached the phase limit),
//          ultimo_sensor (sel is the last sensor).
// Outputs: estado (current state), muda_estado (state changes at next edge,
//          clears the shared counter), inc_sel, carrega / carrega_timeout
//          (load the result registers on entry to registra).
// Macro  : ESCALONADOR_CONTINUO_EN - when defined, fim restarts a round while
//          medir stays high; otherwise fim always returns to inicial.
// -----------------------------------------------------------------------------
module escalonador_sensores_uc
  import escalonador_sensores_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    medir,
  input  logic    echo_sel,
  input  logic    pronto_cm,
  input  logic    fim_trigger,
  input  logic    fim_timeout,
  input  logic    fim_intervalo,
  input  logic    ultimo_sensor,
  output estado_t estado,
  output logic    muda_estado,
  output logic    inc_sel,
  output logic    carrega,
  output logic    carrega_timeout
);

  estado_t proximo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= inicial;
    else       estado <= proximo;
  end

  // The result load is issued on the transition into registra so that
  // medida/sensor/timeout change in the same cycle valido goes high, and
  // medida_cm is captured while pronto_cm is still asserted.
  always_comb begin
    proximo         = estado;
    inc_sel         = 1'b0;
    carrega         = 1'b0;
    carrega_timeout = 1'b0;
    case (estado)
      inicial:  if (medir) proximo = prepara;
      prepara:  proximo = dispara;
      dispara:  if (fim_trigger) proximo = espera_echo;
      espera_echo: begin
        // Echo has priority over a timeout landing in the same cycle.
        if (echo_sel) begin
          proximo = mede;
        end else if (fim_timeout) begin
          proximo         = registra;
          carrega         = 1'b1;
          carrega_timeout = 1'b1;
        end
      end
      mede: begin
        if (pronto_cm) begin
          proximo = registra;
          carrega = 1'b1;
        end else if (fim_timeout) begin
          proximo         = registra;
          carrega         = 1'b1;
          carrega_timeout = 1'b1;
        end
      end
      registra: proximo = intervalo;
      intervalo: begin
        if (fim_intervalo) begin
          if (ultimo_sensor) begin
            proximo = fim;
          end else begin
            proximo = prepara;
            inc_sel = 1'b1;
          end
        end
      end
      fim: begin
`ifdef ESCALONADOR_CONTINUO_EN
        proximo = medir ? prepara : inicial;
`else
        proximo = inicial;
`endif
      end
      default: proximo = inicial;
    endcase
  end

  assign muda_estado = (proximo != estado);

endmodule

// File: rtl/escalonador_sensores.sv
// -----------------------------------------------------------------------------
// escalonador_sensores
// Shares one contador_cm among N_SENSORES ultrasonic sensors: each round
// triggers sensors 0..N-1 in turn, routes the selected echo to contador_cm,
// waits for pronto_cm (or a timeout) and latches the BCD result + index.
// Parameters: N_SENSORES (2..8), LARGURA_TRIGGER, TIMEOUT_CICLOS,
//             INTERVALO_CICLOS (all in clock cycles).
// Ports: clock, reset (async, active-high), bus (escalonador_sensores_if
//        slave: medir/echo/pronto_cm/medida_cm in; trigger/pulso_cm/reset_cm,
//        medida/sensor/valido/timeout, ocupado/fim_rodada/estado out).
// Macro: ESCALONADOR_CONTINUO_EN (see escalonador_sensores_uc).
// -----------------------------------------------------------------------------
module escalonador_sensores
  import escalonador_sensores_pkg::*;
#(
  parameter int N_SENSORES       = N_SENSORES_PADRAO,
  parameter int LARGURA_TRIGGER  = LARGURA_TRIGGER_PADRAO,
  parameter int TIMEOUT_CICLOS   = TIMEOUT_CICLOS_PADRAO,
  parameter int INTERVALO_CICLOS = INTERVALO_CICLOS_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset,
  escalonador_sensores_if.slave   bus
);

  localparam int LARGURA_SENSOR = (N_SENSORES > 1) ? $clog2(N_SENSORES) : 1;
  localparam int MAIOR_AB = (LARGURA_TRIGGER > TIMEOUT_CICLOS) ? LARGURA_TRIGGER
                                                               : TIMEOUT_CICLOS;
  localparam int MAIOR_CICLOS = (MAIOR_AB > INTERVALO_CICLOS) ? MAIOR_AB
                                                               : INTERVALO_CICLOS;
  localparam int LARGURA_CNT = (MAIOR_CICLOS > 1) ? $clog2(MAIOR_CICLOS) : 1;

  localparam logic [LARGURA_CNT-1:0] CNT_TRIGGER   = LARGURA_CNT'(LARGURA_TRIGGER - 1);
  localparam logic [LARGURA_CNT-1:0] CNT_TIMEOUT   = LARGURA_CNT'(TIMEOUT_CICLOS - 1);
  localparam logic [LARGURA_CNT-1:0] CNT_INTERVALO = LARGURA_CNT'(INTERVALO_CICLOS - 1);
  localparam logic [LARGURA_SENSOR-1:0] SEL_ULTIMO = LARGURA_SENSOR'(N_SENSORES - 1);

  estado_t                   estado;
  logic                      muda_estado;
  logic                      inc_sel;
  logic                      carrega;
  logic                      carrega_timeout;
  logic [LARGURA_CNT-1:0]    cnt;
  logic [LARGURA_SENSOR-1:0] sel;
  logic                      echo_sel;

  // Only the selected echo line is ever looked at.
  assign echo_sel = bus.echo[sel];

  escalonador_sensores_uc u_uc (
    .clock           (clock),
    .reset           (reset),
    .medir           (bus.medir),
    .echo_sel        (echo_sel),
    .pronto_cm       (bus.pronto_cm),
    .fim_trigger     (cnt == CNT_TRIGGER),
    .fim_timeout     (cnt == CNT_TIMEOUT),
    .fim_intervalo   (cnt == CNT_INTERVALO),
    .ultimo_sensor   (sel == SEL_ULTIMO),
    .estado          (estado),
    .muda_estado     (muda_estado),
    .inc_sel         (inc_sel),
    .carrega         (carrega),
    .carrega_timeout (carrega_timeout)
  );

  // Shared phase counter: restarts on every state change, saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (muda_estado) cnt <= '0;
    else if (!(&cnt))     cnt <= cnt + 1'b1;
  end

  // sel is held at 0 in inicial and fim so every round starts at sensor 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  sel <= '0;
    else if (estado == inicial || estado == fim) sel <= '0;
    else if (inc_sel)                           sel <= sel + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.medida  <= 12'h000;
      bus.sensor  <= '0;
      bus.timeout <= 1'b0;
    end else if (carrega) begin
      bus.medida  <= carrega_timeout ? MEDIDA_TIMEOUT : bus.medida_cm;
      bus.sensor  <= sel;
      bus.timeout <= carrega_timeout;
    end
  end

  // Moore outputs: decoded from the state only (pulso_cm is the echo gated by
  // the state), so the asynchronous reset of the state drops them at once.
  always_comb begin
    bus.trigger = '0;
    if (estado == dispara) bus.trigger[sel] = 1'b1;
  end

  assign bus.pulso_cm   = (estado == mede) && echo_sel;
  assign bus.reset_cm   = (estado == prepara);
  assign bus.valido     = (estado == registra);
  assign bus.ocupado    = (estado != inicial);
  assign bus.fim_rodada = (estado == fim);
  assign bus.estado     = estado;

endmodule

// File: tb/tb_escalonador_sensores.sv
// -----------------------------------------------------------------------------
// tb_escalonador_sensores
// Directed bench for escalonador_sensores with N_SENSORES=2, LARGURA_TRIGGER=4,
// TIMEOUT_CICLOS=20, INTERVALO_CICLOS=3. Each scenario lays out its input
// waveforms and the expected output timeline in per-cycle tables (cycle n is
// the interval after rising edge n, inputs driven at the falling edge), then
// replays them and compares every output every cycle. Hand-computed event
// cycles and values pin the timeline model. Honours ESCALONADOR_CONTINUO_EN.
// -----------------------------------------------------------------------------
module tb_escalonador_sensores;
  import escalonador_sensores_pkg::*;

  localparam int N  = 2;
  localparam int LT = 4;
  localparam int TO = 20;
  localparam int IV = 3;
  localparam int K  = 80;
  localparam int NONE  = 1000;
  localparam int STUCK = -1;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  escalonador_sensores_if #(.N_SENSORES(N)) bus ();

  escalonador_sensores #(
    .N_SENSORES       (N),
    .LARGURA_TRIGGER  (LT),
    .TIMEOUT_CICLOS   (TO),
    .INTERVALO_CICLOS (IV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus tables
  bit          medir_drv  [K];
  bit          rst_drv    [K];
  logic [N-1:0] echo_drv  [K];
  bit          pronto_drv [K];
  logic [11:0] mcm_drv    [K];

  // expected timeline
  logic [N-1:0] x_trig [K];
  bit          x_rcm  [K];
  bit          x_val  [K];
  bit          x_ocp  [K];
  bit          x_fim  [K];
  int          x_mede [K];   // sensor whose echo feeds pulso_cm, -1 = none
  logic [11:0] x_med  [K];
  int          x_sen  [K];
  bit          x_tmo  [K];

  // per-sensor plan: echo rise offset from espera_echo entry, echo length,
  // pronto offset from mede entry, value on medida_cm with pronto
  int          plan_a   [N];
  int          plan_len [N];
  int          plan_b   [N];
  logic [11:0] plan_v   [N];

  // model result registers
  logic [11:0] m_med;
  int          m_sen;
  bit          m_tmo;

  int checks   = 0;
  int failures = 0;

  // observed events (for hand-computed pins)
  int          val_cyc[$];
  logic [11:0] val_med[$];
  int          fim_cyc[$];
  int          trig_cnt [N];
  int          pulso_cnt;
  int          ocp_low_cnt;
  int          ocp_lim;
  int          first_trig_cyc;
  logic [N-1:0] first_trig_val;
  int          trig_after;

  task automatic chk(input string nome, input int n, input string campo,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d %s: got %0h expected %0h", nome, n, campo, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int n = 0; n < K; n++) begin
      medir_drv[n]  = 1'b0;
      rst_drv[n]    = 1'b0;
      echo_drv[n]   = '0;
      pronto_drv[n] = 1'b0;
      mcm_drv[n]    = 12'habc;
    end
  endtask

  task automatic model_reset();
    m_med = 12'h000;
    m_sen = 0;
    m_tmo = 1'b0;
  endtask

  task automatic model_idle(input int from);
    for (int n = from; n < K; n++) begin
      x_trig[n] = '0;
      x_rcm[n]  = 1'b0;
      x_val[n]  = 1'b0;
      x_ocp[n]  = 1'b0;
      x_fim[n]  = 1'b0;
      x_mede[n] = -1;
      x_med[n]  = m_med;
      x_sen[n]  = m_sen;
      x_tmo[n]  = m_tmo;
    end
  endtask

  // One round whose medir is seen in cycle m; returns the fim cycle.
  task automatic model_round(input int m, output int f);
    int p, e, rise, mm, q, r;
    logic [N-1:0] oh;
    p = m + 1;
    f = K;
    for (int i = 0; i < N; i++) begin
      oh = '0;
      oh[i] = 1'b1;
      if (p < K) x_rcm[p] = 1'b1;
      for (int c = p + 1; c <= p + LT && c < K; c++) x_trig[c] = oh;
      e  = p + LT + 1;
      mm = -1;
      if (plan_a[i] == STUCK) begin
        for (int c = 0; c < K; c++) echo_drv[c][i] = 1'b1;
        rise = e;
      end else if (plan_a[i] == NONE) begin
        rise = NONE;
      end else begin
        rise = e + plan_a[i];
        for (int c = rise; c < rise + plan_len[i] && c < K; c++) echo_drv[c][i] = 1'b1;
      end
      if (rise > e + TO - 1) begin
        r = e + TO;
        m_med = MEDIDA_TIMEOUT;
        m_tmo = 1'b1;
      end else begin
        mm = rise + 1;
        if (plan_b[i] != NONE && plan_b[i] <= TO - 1) begin
          q = mm + plan_b[i];
          if (q < K) begin
            pronto_drv[q] = 1'b1;
            mcm_drv[q]    = plan_v[i];
          end
          r = q + 1;
          m_med = plan_v[i];
          m_tmo = 1'b0;
        end else begin
          r = mm + TO;
          m_med = MEDIDA_TIMEOUT;
          m_tmo = 1'b1;
        end
        for (int c = mm; c < r && c < K; c++) x_mede[c] = i;
      end
      m_sen = i;
      for (int c = p; c <= r + IV && c < K; c++) x_ocp[c] = 1'b1;
      if (r < K) x_val[r] = 1'b1;
      for (int c = r; c < K; c++) begin
        x_med[c] = m_med;
        x_sen[c] = m_sen;
        x_tmo[c] = m_tmo;
      end
      if (i == N - 1) begin
        f = r + IV + 1;
        if (f < K) begin
          x_fim[f] = 1'b1;
          x_ocp[f] = 1'b1;
        end
      end else begin
        p = r + IV + 1;
      end
    end
  endtask

  task automatic compare(input string nome, input int n);
    logic exp_pulso;
    exp_pulso = (x_mede[n] >= 0) ? echo_drv[n][x_mede[n]] : 1'b0;
    chk(nome, n, "trigger",    bus.trigger,    x_trig[n]);
    chk(nome, n, "reset_cm",   bus.reset_cm,   x_rcm[n]);
    chk(nome, n, "pulso_cm",   bus.pulso_cm,   exp_pulso);
    chk(nome, n, "valido",     bus.valido,     x_val[n]);
    chk(nome, n, "ocupado",    bus.ocupado,    x_ocp[n]);
    chk(nome, n, "fim_rodada", bus.fim_rodada, x_fim[n]);
    chk(nome, n, "medida",     bus.medida,     x_med[n]);
    chk(nome, n, "sensor",     bus.sensor,     x_sen[n]);
    chk(nome, n, "timeout",    bus.timeout,    x_tmo[n]);
  endtask

  task automatic record(input int n);
    if (bus.valido === 1'b1) begin
      val_cyc.push_back(n);
      val_med.push_back(bus.medida);
    end
    if (bus.fim_rodada === 1'b1) fim_cyc.push_back(n);
    for (int i = 0; i < N; i++)
      if (bus.trigger[i] === 1'b1) trig_cnt[i]++;
    if (bus.pulso_cm === 1'b1) pulso_cnt++;
    if (n >= 1 && n <= ocp_lim && bus.ocupado !== 1'b1) ocp_low_cnt++;
    if (first_trig_cyc < 0 && n > trig_after && bus.trigger != '0) begin
      first_trig_cyc = n;
      first_trig_val = bus.trigger;
    end
  endtask

  // driver: reset the DUT, then replay the tables and compare each cycle
  task automatic run(input string nome);
    val_cyc.delete();
    val_med.delete();
    fim_cyc.delete();
    for (int i = 0; i < N; i++) trig_cnt[i] = 0;
    pulso_cnt      = 0;
    ocp_low_cnt    = 0;
    first_trig_cyc = -1;
    first_trig_val = '0;
    reset         = 1'b1;
    bus.medir     = 1'b0;
    bus.echo      = '0;
    bus.pronto_cm = 1'b0;
    bus.medida_cm = 12'habc;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < K; n++) begin
      @(negedge clock);
      reset         = rst_drv[n];
      bus.medir     = medir_drv[n];
      bus.echo      = echo_drv[n];
      bus.pronto_cm = pronto_drv[n];
      bus.medida_cm = mcm_drv[n];
      #1;
      compare(nome, n);
      record(n);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [11:0] qm(input logic [11:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 12'hfff;
  endfunction

  initial begin
    int f1, f2, m2;
    ocp_lim    = 0;
    trig_after = K;

    // nominal round: echo 8 cycles after each trigger, pronto with 123 / 045
    clear_stim(); model_reset(); model_idle(0);
    plan_a = '{7, 7}; plan_len = '{5, 5}; plan_b = '{4, 4}; plan_v = '{12'h123, 12'h045};
    medir_drv[1] = 1'b1;
    model_round(1, f1);
    run("nominal");
    chk("nominal", -1, "n_valido",  val_cyc.size(), 2);
    chk("nominal", -1, "valido0",   qi(val_cyc, 0), 20);
    chk("nominal", -1, "valido1",   qi(val_cyc, 1), 42);
    chk("nominal", -1, "medida0",   qm(val_med, 0), 12'h123);
    chk("nominal", -1, "medida1",   qm(val_med, 1), 12'h045);
    chk("nominal", -1, "fim",       qi(fim_cyc, 0), 46);
    chk("nominal", -1, "n_fim",     fim_cyc.size(), 1);
    chk("nominal", -1, "trig0_len", trig_cnt[0], 4);
    chk("nominal", -1, "trig1_len", trig_cnt[1], 4);

    // sensor 0 never echoes: timeout from espera_echo
    clear_stim(); model_reset(); model_idle(0);
    plan_a = '{NONE, 2}; plan_len = '{0, 2}; plan_b = '{NONE, 2}; plan_v = '{12'h777, 12'h045};
    medir_drv[1] = 1'b1;
    model_round(1, f1);
    run("no_echo");
    chk("no_echo", -1, "valido0", qi(val_cyc, 0), 27);
    chk("no_echo", -1, "medida0", qm(val_med, 0), 12'h999);
    chk("no_echo", -1, "valido1", qi(val_cyc, 1), 42);
    chk("no_echo", -1, "medida1", qm(val_med, 1), 12'h045);
    chk("no_echo", -1, "fim",     qi(fim_cyc, 0), 46);

    // echo[0] stuck high, no pronto: timeout from mede
    clear_stim(); model_reset(); model_idle(0);
    plan_a = '{STUCK, 1}; plan_len = '{0, 2}; plan_b = '{NONE, 1}; plan_v = '{12'h555, 12'h067};
    medir_drv[1] = 1'b1;
    model_round(1, f1);
    run("stuck");
    chk("stuck", -1, "valido0",   qi(val_cyc, 0), 28);
    chk("stuck", -1, "medida0",   qm(val_med, 0), 12'h999);
    chk("stuck", -1, "valido1",   qi(val_cyc, 1), 41);
    chk("stuck", -1, "fim",       qi(fim_cyc, 0), 45);
    chk("stuck", -1, "pulso_len", pulso_cnt, 21);

    // reset during dispara, then a fresh round
    clear_stim(); model_reset(); model_idle(0);
    plan_a = '{NONE, NONE}; plan_len = '{0, 0}; plan_b = '{NONE, NONE}; plan_v = '{12'h0, 12'h0};
    medir_drv[1] = 1'b1;
    model_round(1, f1);
    rst_drv[5] = 1'b1;
    model_reset(); model_idle(5);
    plan_a = '{2, 2}; plan_len = '{2, 2}; plan_b = '{2, 2}; plan_v = '{12'h321, 12'h054};
    medir_drv[8] = 1'b1;
    model_round(8, f1);
    trig_after = 5;
    run("reset_mid");
    trig_after = K;
    chk("reset_mid", -1, "restart_cyc", first_trig_cyc, 10);
    chk("reset_mid", -1, "restart_trg", first_trig_val, 2'b01);
    chk("reset_mid", -1, "valido0",     qi(val_cyc, 0), 20);
    chk("reset_mid", -1, "medida0",     qm(val_med, 0), 12'h321);
    chk("reset_mid", -1, "valido1",     qi(val_cyc, 1), 35);
    chk("reset_mid", -1, "fim",         qi(fim_cyc, 0), 39);

    // medir held high across two rounds, dropped in the second fim
    clear_stim(); model_reset(); model_idle(0);
    plan_a = '{1, 1}; plan_len = '{2, 2}; plan_b = '{1, 1}; plan_v = '{12'h111, 12'h222};
    model_round(0, f1);
`ifdef ESCALONADOR_CONTINUO_EN
    m2 = f1;
`else
    m2 = f1 + 1;
`endif
    model_round(m2, f2);
    for (int n = 0; n < f2 && n < K; n++) medir_drv[n] = 1'b1;
    ocp_lim = f2;
    run("held");
    ocp_lim = 0;
    chk("held", -1, "n_valido", val_cyc.size(), 4);
    chk("held", -1, "fim0",     qi(fim_cyc, 0), 27);
    chk("held", -1, "n_fim",    fim_cyc.size(), 2);
`ifdef ESCALONADOR_CONTINUO_EN
    chk("held", -1, "fim1",     qi(fim_cyc, 1), 54);
    chk("held", -1, "ocp_gaps", ocp_low_cnt, 0);
`else
    chk("held", -1, "fim1",     qi(fim_cyc, 1), 55);
    chk("held", -1, "ocp_gaps", ocp_low_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/escalonador_sensores.md
# escalonador_sensores

Measurement scheduler that shares one `contador_cm` distance-counting datapath among `N_SENSORES` ultrasonic sensors. Each round visits the sensors in order 0..N-1:
- fires a trigger pulse on the selected sensor;
- routes that sensor's echo into the counter as `pulso`;
- waits for the counter's `pronto`, or a timeout;
- latches the BCD result with the sensor index.

The block sits between the sensor pins and the single `contador_cm` instance in the top level.

## Interface
- `N_SENSORES`, 4: number of sensors, 2..8.
- `LARGURA_TRIGGER`, 500: trigger high time in clock cycles (10 µs at 50 MHz).
- `TIMEOUT_CICLOS`, 1_500_000: maximum cycles per wait phase (echo start, echo end).
- `INTERVALO_CICLOS`, 3_000_000: idle cycles between consecutive sensors.
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `medir` in 1: start one round; level-sampled in `inicial`.
- `echo` in N_SENSORES: echo lines, already synchronized.
- `pronto_cm` in 1: `pronto` from `contador_cm`.
- `medida_cm` in 12: 3-digit BCD count from `contador_cm`.
- `trigger` out N_SENSORES: one-hot trigger pulse.
- `pulso_cm` out 1: drives `contador_cm` `pulso`.
- `reset_cm` out 1: clears `contador_cm`.
- `medida` out 12: last latched BCD distance.
- `sensor` out clog2(N_SENSORES): index of the last latched measurement.
- `valido` out 1: one-cycle pulse when `medida`/`sensor` update.
- `timeout` out 1: latched with `medida`; 1 when that measurement timed out.
- `ocupado` out 1: high whenever the state is not `inicial`.
- `fim_rodada` out 1: one-cycle pulse after the last sensor.

## Operation
- The FSM is Moore. One shared cycle counter `cnt` clears on every state change.
- `sel` is the current sensor index.
- `inicial`:
  - `sel`=0.
  - `medir`=1 → `prepara`.
- `prepara`: one cycle, `reset_cm`=1 → `dispara`.
- `dispara`:
  - `trigger[sel]`=1 for exactly `LARGURA_TRIGGER` cycles.
  - When `cnt`=LARGURA_TRIGGER-1 → `espera_echo`.
- `espera_echo`:
  - `echo[sel]`=1 → `mede`.
  - Else `cnt`=TIMEOUT_CICLOS-1 → `registra` with timeout.
  - If both conditions occur in the same cycle, echo wins.
- `mede`:
  - `pulso_cm`=`echo[sel]` (combinational, gated by the state).
  - `pronto_cm`=1 → `registra` with no timeout.
  - Else `cnt`=TIMEOUT_CICLOS-1 → `registra` with timeout.
  - If both occur in the same cycle, `pronto_cm` wins.
- `registra`: one cycle.
  - `valido`=1.
  - `medida`←`medida_cm`, or 12'h999 on timeout.
  - `sensor`←`sel`; `timeout`←flag.
  - Then → `intervalo`.
- `intervalo`: when `cnt`=INTERVALO_CICLOS-1:
  - if `sel`=N_SENSORES-1 → `fim`;
  - else `sel`←`sel`+1 → `prepara`.
- `fim`: one cycle, `fim_rodada`=1 → `inicial`.
- Any unused state encoding → `inicial`.
- `medir` is ignored while `ocupado`=1.
- An `echo[sel]` line already high on entry to `espera_echo` counts as echo start.
- Non-selected `echo` bits are ignored at all times.
- `cnt` width is clog2 of the largest cycle parameter; it saturates and never wraps.

## Timing
- Reset values:
  - state=`inicial`, `sel`=0, `cnt`=0;
  - `trigger`=0, `pulso_cm`=0, `reset_cm`=0;
  - `medida`=12'h000, `sensor`=0;
  - `valido`=0, `timeout`=0, `ocupado`=0, `fim_rodada`=0.
- Reset mid-operation: `trigger` drops asynchronously and the latched result clears.
- `medir` high at edge k → `ocupado` and `reset_cm` high from k+1 → `trigger[0]` high over edges k+2 .. k+1+LARGURA_TRIGGER.
- `pronto_cm` at edge j → `valido` at j+1, with `medida` already updated at that edge.
- Timeout path: `registra` follows `espera_echo`/`mede` entry by exactly TIMEOUT_CICLOS cycles.
- `fim_rodada` comes 1 + INTERVALO_CICLOS cycles after the last `valido`.

## Configuration
- `ESCALONADOR_CONTINUO_EN` defined:
  - `fim` → `prepara` with `sel`=0; rounds repeat without `medir`.
  - `medir`=0 observed in `fim` → `inicial` instead.
- Not defined: `fim` → `inicial` always; each round needs `medir`.

## Structure
- Shared package holds:
  - state encodings `inicial`..`fim` (3 bits);
  - the timeout BCD constant 12'h999;
  - default cycle constants.
- One sub-module is natural: `escalonador_sensores_uc` (FSM). `cnt`, `sel`, and the result registers live in the top-level datapath.

## Test plan
All scenarios use N_SENSORES=2, LARGURA_TRIGGER=4, TIMEOUT_CICLOS=20, INTERVALO_CICLOS=3.
- Nominal round:
  - Stimulus: `medir` pulse; `echo[0]` high 8 cycles after trigger, `pronto_cm` with `medida_cm`=12'h123; same for sensor 1 with 12'h045.
  - Response: two `valido` pulses, (sensor 0, 123, `timeout`=0) then (sensor 1, 045, `timeout`=0), then `fim_rodada` once.
- Trigger width: `trigger[0]` is high exactly 4 cycles and `trigger[1]` stays 0 meanwhile.
- No echo on sensor 0: `valido` comes 20 cycles after entering `espera_echo`, with `medida`=999, `timeout`=1; sensor 1 still measured.
- Echo stuck high and no `pronto_cm`: timeout from `mede` gives `medida`=999, `timeout`=1; `pulso_cm` follows `echo[0]` only in `mede`.
- Reset asserted during `dispara`: `trigger`=0 immediately, all outputs at reset values; a new `medir` restarts at sensor 0.
- With `ESCALONADOR_CONTINUO_EN`: `medir` held high yields back-to-back rounds, and `ocupado` never drops.
